regfile_wr_arbiter: RTL and testbench

Shares the register file's single write port (write enable, 3-bit write address, 16-bit write data) between the writeback stage and an auxiliary writer such as a multi-cycle load return or a context restore. Writeback has fixed priority, and auxiliary writes that lose arbitration are buffered in a small FIFO. A starvation counter forces a queued write through by stalling writeback. Per-register busy bits let decode stall reads of registers that still have a queued write.

---
 rtl/regfile_arb_pkg.sv | 24 ++
 rtl/aux_wr_fifo.sv | 78 +++++++
 rtl/regfile_wr_arbiter.sv | 108 ++++++++++
 tb/tb_regfile_wr_arbiter.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/regfile_arb_pkg.sv
// Shared types and defaults for the register-file write-port arbiter.
package regfile_arb_pkg;

  localparam int W_DEF        = 16;
  localparam int N_DEF        = 3;
  localparam int DEPTH_DEF    = 2;
  localparam int MAX_WAIT_DEF = 4;

  typedef enum logic [2:0] {
    GNT_IDLE,
    GNT_WB,
    GNT_HEAD,
    GNT_BYPASS,
    GNT_FORCE
  } grant_e;

  // Queued aux write at the default widths; the FIFO mirrors this layout per instance.
  typedef struct packed {
    logic                 valid;
    logic [N_DEF-1:0]     addr;
    logic [W_DEF-1:0]     data;
  } aux_entry_t;

endpackage

// File: rtl/aux_wr_fifo.sv
// Auxiliary write queue: circular storage with per-entry valid bits, address-match
// invalidation against the writeback destination, and a per-register busy vector.
module aux_wr_fifo #(
  parameter int W     = 16,
  parameter int N     = 3,
  parameter int DEPTH = 2,
  localparam int CW   = $clog2(DEPTH+1),
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [N-1:0]    push_addr,
  input  logic [W-1:0]    push_data,
  input  logic            pop,
  input  logic            inv_en,
  input  logic [N-1:0]    inv_addr,
  output logic            head_valid,
  output logic [N-1:0]    head_addr,
  output logic [W-1:0]    head_data,
  output logic [CW-1:0]   count,
  output logic [2**N-1:0] busy
);

  typedef struct packed {
    logic         valid;
    logic [N-1:0] addr;
    logic [W-1:0] data;
  } entry_t;

  entry_t [DEPTH-1:0] ent_q;
  logic [PW-1:0]      head_q, tail_q;
  logic [CW-1:0]      count_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  // Push wins over pop/invalidate so a same-cycle enqueue is never killed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ent_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (push && tail_q == PW'(i))
          ent_q[i] <= '{valid: 1'b1, addr: push_addr, data: push_data};
        else if (pop && head_q == PW'(i))
          ent_q[i].valid <= 1'b0;
        else if (inv_en && ent_q[i].addr == inv_addr)
          ent_q[i].valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (pop)  head_q <= ptr_inc(head_q);
      if (push) tail_q <= ptr_inc(tail_q);
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < DEPTH; i++)
      if (ent_q[i].valid) busy[ent_q[i].addr] = 1'b1;
  end

  assign head_valid = ent_q[head_q].valid;
  assign head_addr  = ent_q[head_q].addr;
  assign head_data  = ent_q[head_q].data;
  assign count      = count_q;

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Single register-file write port shared by writeback (priority) and an aux writer,
// with a queued-aux starvation guard that stalls writeback for one cycle.
module regfile_wr_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int W        = W_DEF,
  parameter int N        = N_DEF,
  parameter int DEPTH    = DEPTH_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF,
  localparam int CW      = $clog2(DEPTH+1),
  localparam int WCW     = $clog2(MAX_WAIT+1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_valid,
  input  logic [N-1:0]    wb_addr,
  input  logic [W-1:0]    wb_data,
  output logic            wb_stall,
  input  logic            aux_valid,
  input  logic [N-1:0]    aux_addr,
  input  logic [W-1:0]    aux_data,
  output logic            aux_ready,
  output logic            regWrite,
  output logic [N-1:0]    WA,
  output logic [W-1:0]    WD,
  output logic [2**N-1:0] busy,
  output logic [CW-1:0]   fifo_count
);

  grant_e         gnt;
  logic           fifo_ne, pop, push;
  logic           head_valid;
  logic [N-1:0]   head_addr;
  logic [W-1:0]   head_data;
  logic [WCW-1:0] wait_q, wait_d;

  assign fifo_ne = (fifo_count != '0);

  // Holding reset forces IDLE so neither WB nor a bypass reaches the port.
  always_comb begin
    gnt = GNT_IDLE;
    if (!rst)                                  gnt = GNT_IDLE;
    else if (wait_q == WCW'(MAX_WAIT) && fifo_ne) gnt = GNT_FORCE;
    else if (wb_valid)                         gnt = GNT_WB;
    else if (fifo_ne)                          gnt = GNT_HEAD;
    else if (aux_valid)                        gnt = GNT_BYPASS;
  end

  assign pop       = (gnt == GNT_FORCE) || (gnt == GNT_HEAD);
  assign aux_ready = (fifo_count < CW'(DEPTH)) || pop;
  assign push      = rst && aux_valid && aux_ready && (gnt != GNT_BYPASS);
  assign wb_stall  = (gnt == GNT_FORCE) && wb_valid;

  // A bubble at the head pops silently; WA/WD stay 0 whenever nothing is written.
  always_comb begin
    regWrite = 1'b0;
    WA       = '0;
    WD       = '0;
    case (gnt)
      GNT_WB: begin
        regWrite = 1'b1;
        WA       = wb_addr;
        WD       = wb_data;
      end
      GNT_BYPASS: begin
        regWrite = 1'b1;
        WA       = aux_addr;
        WD       = aux_data;
      end
      GNT_HEAD, GNT_FORCE: begin
        if (head_valid) begin
          regWrite = 1'b1;
          WA       = head_addr;
          WD       = head_data;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    wait_d = wait_q;
    if (!fifo_ne || pop)            wait_d = '0;
    else if (wait_q != WCW'(MAX_WAIT)) wait_d = wait_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wait_q <= '0;
    else      wait_q <= wait_d;
  end

  aux_wr_fifo #(.W(W), .N(N), .DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_addr  (aux_addr),
    .push_data  (aux_data),
    .pop        (pop),
    .inv_en     (gnt == GNT_WB),
    .inv_addr   (wb_addr),
    .head_valid (head_valid),
    .head_addr  (head_addr),
    .head_data  (head_data),
    .count      (fifo_count),
    .busy       (busy)
  );

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed vector bench for regfile_wr_arbiter (W=16, N=3, DEPTH=2, MAX_WAIT=4).
module tb_regfile_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid, aux_valid;
  logic [2:0]  wb_addr, aux_addr;
  logic [15:0] wb_data, aux_data;
  logic        wb_stall, aux_ready, regWrite;
  logic [2:0]  WA;
  logic [15:0] WD;
  logic [7:0]  busy;
  logic [1:0]  fifo_count;

  int checks   = 0;
  int failures = 0;
  int rw_seen  = 0;

  always #5 clk = ~clk;

  regfile_wr_arbiter #(.W(16), .N(3), .DEPTH(2), .MAX_WAIT(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .wb_valid   (wb_valid),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .wb_stall   (wb_stall),
    .aux_valid  (aux_valid),
    .aux_addr   (aux_addr),
    .aux_data   (aux_data),
    .aux_ready  (aux_ready),
    .regWrite   (regWrite),
    .WA         (WA),
    .WD         (WD),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  typedef struct {
    logic        rst;
    logic        wbv;
    logic [2:0]  wba;
    logic [15:0] wbd;
    logic        auxv;
    logic [2:0]  auxa;
    logic [15:0] auxd;
    logic        stall;
    logic        rdy;
    logic        rw;
    logic [2:0]  wa;
    logic [15:0] wd;
    logic [7:0]  busy;
    logic [1:0]  cnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(input logic r, input logic wv, input logic [2:0] wa_i,
                             input logic [15:0] wd_i, input logic av, input logic [2:0] aa,
                             input logic [15:0] ad, input logic st, input logic rd,
                             input logic rw, input logic [2:0] ewa, input logic [15:0] ewd,
                             input logic [7:0] eb, input logic [1:0] ec);
    vec_t t;
    t.rst = r; t.wbv = wv; t.wba = wa_i; t.wbd = wd_i;
    t.auxv = av; t.auxa = aa; t.auxd = ad;
    t.stall = st; t.rdy = rd; t.rw = rw; t.wa = ewa; t.wd = ewd; t.busy = eb; t.cnt = ec;
    return t;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=%0h exp=%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    rst = t.rst; wb_valid = t.wbv; wb_addr = t.wba; wb_data = t.wbd;
    aux_valid = t.auxv; aux_addr = t.auxa; aux_data = t.auxd;
  endtask

  task automatic check_vec(input vec_t t, input int idx);
    chk("wb_stall",   idx, 32'(wb_stall),   32'(t.stall));
    chk("aux_ready",  idx, 32'(aux_ready),  32'(t.rdy));
    chk("regWrite",   idx, 32'(regWrite),   32'(t.rw));
    chk("WA",         idx, 32'(WA),         32'(t.wa));
    chk("WD",         idx, 32'(WD),         32'(t.wd));
    chk("busy",       idx, 32'(busy),       32'(t.busy));
    chk("fifo_count", idx, 32'(fifo_count), 32'(t.cnt));
  endtask

  initial begin
    rst = 1'b0; wb_valid = 0; aux_valid = 0;
    wb_addr = 0; wb_data = 0; aux_addr = 0; aux_data = 0;

    //        rst wbv wba wbd      av aa ad       st rdy rw wa wd       busy   cnt
    // reset held with both requesters active: everything suppressed
    tbl.push_back(v(0, 1, 2, 16'hBEEF, 1, 5, 16'h1111, 0, 1, 0, 0, 16'h0000, 8'h00, 0));
    // bypass
    tbl.push_back(v(1, 0, 0, 16'h0000, 1, 5, 16'h1234, 0, 1, 1, 5, 16'h1234, 8'h00, 0));
    // collision: WB wins, r3 queued; busy only next cycle
    tbl.push_back(v(1, 1, 2, 16'hAAAA, 1, 3, 16'h5555, 0, 1, 1, 2, 16'hAAAA, 8'h00, 0));
    tbl.push_back(v(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 1, 3, 16'h5555, 8'h08, 1));
    tbl.push_back(v(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 8'h00, 0));
    // invalidate: queue r4, WB to r4, bubble pops silently
    tbl.push_back(v(1, 1, 1, 16'h0101, 1, 4, 16'h4444, 0, 1, 1, 1, 16'h0101, 8'h00, 0));
    tbl.push_back(v(1, 1, 4, 16'h9999, 0, 0, 16'h0000, 0, 1, 1, 4, 16'h9999, 8'h10, 1));
    tbl.push_back(v(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 8'h00, 1));
    tbl.push_back(v(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 8'h00, 0));
    // starvation: r1 queued, 4 blocked WB cycles, then forced grant + stall
    tbl.push_back(v(1, 1, 0, 16'h0A0A, 1, 1, 16'h1111, 0, 1, 1, 0, 16'h0A0A, 8'h00, 0));
    tbl.push_back(v(1, 1, 6, 16'h0B0B, 0, 0, 16'h0000, 0, 1, 1, 6, 16'h0B0B, 8'h02, 1));
    tbl.push_back(v(1, 1, 6, 16'h0C0C, 0, 0, 16'h0000, 0, 1, 1, 6, 16'h0C0C, 8'h02, 1));
    tbl.push_back(v(1, 1, 6, 16'h0C0D, 0, 0, 16'h0000, 0, 1, 1, 6, 16'h0C0D, 8'h02, 1));
    tbl.push_back(v(1, 1, 6, 16'h0C0E, 0, 0, 16'h0000, 0, 1, 1, 6, 16'h0C0E, 8'h02, 1));
    tbl.push_back(v(1, 1, 6, 16'h0D0D, 0, 0, 16'h0000, 1, 1, 1, 1, 16'h1111, 8'h02, 1));
    tbl.push_back(v(1, 1, 6, 16'h0D0D, 0, 0, 16'h0000, 0, 1, 1, 6, 16'h0D0D, 8'h00, 0));
    // full: two queued under WB, third offer held, push-with-pop keeps count 2
    tbl.push_back(v(1, 1, 6, 16'h6001, 1, 3, 16'h3001, 0, 1, 1, 6, 16'h6001, 8'h00, 0));
    tbl.push_back(v(1, 1, 6, 16'h6002, 1, 5, 16'h5001, 0, 1, 1, 6, 16'h6002, 8'h08, 1));
    tbl.push_back(v(1, 1, 6, 16'h6003, 1, 7, 16'h7001, 0, 0, 1, 6, 16'h6003, 8'h28, 2));
    tbl.push_back(v(1, 0, 0, 16'h0000, 1, 7, 16'h7001, 0, 1, 1, 3, 16'h3001, 8'h28, 2));
    tbl.push_back(v(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 1, 5, 16'h5001, 8'hA0, 2));
    // refill to two entries, then asynchronous reset drops them
    tbl.push_back(v(1, 1, 6, 16'h6004, 1, 1, 16'h1002, 0, 1, 1, 6, 16'h6004, 8'h80, 1));
    tbl.push_back(v(0, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 8'h00, 0));
    tbl.push_back(v(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 8'h00, 0));
    tbl.push_back(v(1, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 0, 0, 16'h0000, 8'h00, 0));

    // inputs change just after the rising edge, so a low rst takes effect with no edge
    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk); #1;
      drive(tbl[i]);
      @(negedge clk);
      check_vec(tbl[i], i);
    end

    // mid-cycle reset with two entries queued: state clears before any edge
    @(posedge clk); #1;
    rst = 1; wb_valid = 1; wb_addr = 0; wb_data = 16'h0F01;
    aux_valid = 1; aux_addr = 2; aux_data = 16'h2222;
    @(posedge clk); #1;
    wb_data = 16'h0F02; aux_addr = 4; aux_data = 16'h4444;
    @(posedge clk); #1;
    wb_valid = 0; aux_valid = 0;
    chk("pre_rst_count", 100, 32'(fifo_count), 32'd2);
    chk("pre_rst_busy",  100, 32'(busy),       32'h14);
    #2 rst = 0;
    #1;
    chk("async_count", 101, 32'(fifo_count), 32'd0);
    chk("async_busy",  101, 32'(busy),       32'h00);
    chk("async_rw",    101, 32'(regWrite),   32'd0);
    chk("async_ready", 101, 32'(aux_ready),  32'd1);
    @(posedge clk); #1;
    rst = 1;
    rw_seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (regWrite) rw_seen++;
    end
    chk("dropped_writes", 102, 32'(rw_seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
